// File: rtl/nibble_serial_addsub.sv
// rtl/nibble_serial_addsub.sv - nibble-serial signed add/sub through one 4-bit CLA slice; optional clamp under SATURATE_EN

// 4-bit carry-lookahead slice. ovfl is the signed overflow of this slice
// taken as the top nibble: carry into bit 3 xor carry out of bit 3.
module nibble_serial_addsub_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       ovfl
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];
    assign ovfl = c[4] ^ c[3];
endmodule

// Ports: start_valid/start_ready accept op_a, op_b, sub; result with
// flag_z/flag_v/flag_n/cout is offered on result_valid/result_ready.
module nibble_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n,
    output logic             cout
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;    // already inverted for subtraction
    logic             carry;
    logic [IDXW-1:0]  nib_idx;
    logic [IDXW+1:0]  base;     // bit offset of the current nibble

    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic             slice_ovfl;
    logic [WIDTH-1:0] final_raw;
    logic [WIDTH-1:0] final_res;

    assign base    = {nib_idx, 2'b00};
    assign slice_a = a_reg[base +: 4];
    assign slice_b = b_reg[base +: 4];

    nibble_serial_addsub_cla4 u_cla (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout),
        .ovfl (slice_ovfl)
    );

    // Lower nibbles are already stored by the time the top nibble is summed.
    assign final_raw = {slice_sum, result[WIDTH-5:0]};

`ifdef SATURATE_EN
    // Overflow is only possible when both addends share a sign, so the sign of
    // op_a picks the clamp direction.
    assign final_res = slice_ovfl ? (a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                    : {1'b0, {(WIDTH-1){1'b1}}})
                                  : final_raw;
`else
    assign final_res = final_raw;
`endif

    assign start_ready  = (state == IDLE);
    assign result_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            carry   <= 1'b0;
            nib_idx <= '0;
            result  <= '0;
            flag_z  <= 1'b0;
            flag_v  <= 1'b0;
            flag_n  <= 1'b0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_reg   <= op_a;
                        b_reg   <= op_b ^ {WIDTH{sub}};
                        carry   <= sub;   // +1 completes the two's complement of B
                        nib_idx <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    carry <= slice_cout;
                    if (nib_idx == LAST_IDX) begin
                        result <= final_res;
                        flag_z <= (final_res == '0);
                        flag_n <= final_res[WIDTH-1];
                        flag_v <= slice_ovfl;
                        cout   <= slice_cout;
                        state  <= DONE;
                    end else begin
                        result[base +: 4] <= slice_sum;
                        nib_idx           <= nib_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
